// File: rtl/clahe_pkg.sv
// clahe_pkg: shared widths, tag bit positions and a width helper for the CLAHE output stage.
package clahe_pkg;
    localparam int PIX_W   = 24;
    localparam int TAG_W   = 2;
    localparam int TAG_SOF = 25;
    localparam int TAG_EOL = 24;

    // Ceiling log2, never below 1 so single-value counters still get a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/axis_fwft_fifo.sv
// axis_fwft_fifo: first-word-fall-through FIFO; head entry is visible on rd_data while not empty.
module axis_fwft_fifo
    import clahe_pkg::*;
#(
    parameter int DW    = 26,
    parameter int DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DW-1:0]           wr_data,
    output logic                    full,
    input  logic                    rd_en,
    output logic [DW-1:0]           rd_data,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);
    localparam int AW = clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    // A write while full is lost even when a read frees a slot in the same cycle.
    assign full    = r_count == (AW+1)'(DEPTH);
    assign empty   = r_count == '0;
    assign count   = r_count;
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_rd ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count  <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/clahe_axis_out.sv
// clahe_axis_out: tags CLAHE pixels with sof/eol, buffers them and drives an AXI4-Stream video master.
// Optional CLAHE_AXIS_OUT_FRAME_CNT_EN adds frame_cnt and drop_cnt outputs.
module clahe_axis_out
    import clahe_pkg::*;
#(
    parameter int WIDTH      = 1920,
    parameter int HEIGHT     = 1080,
    parameter int FIFO_DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               src_valid,
    input  logic [PIX_W-1:0]   src_data,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [PIX_W-1:0]   m_axis_tdata,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               overflow,
    input  logic               clr_overflow,
    output logic               frame_done
`ifdef CLAHE_AXIS_OUT_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        drop_cnt
`endif
);
    localparam int CW = clog2(WIDTH);
    localparam int RW = clog2(HEIGHT);
    localparam int AW = clog2(FIFO_DEPTH);

    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic                     r_frame_done;
    logic                     r_overflow;
    logic                     w_last_col;
    logic                     w_last_row;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_drop;
    logic [AW:0]              w_count;
    logic [PIX_W+TAG_W-1:0]   w_wr_data;
    logic [PIX_W+TAG_W-1:0]   w_rd_data;

    assign w_last_col = r_col == CW'(WIDTH - 1);
    assign w_last_row = r_row == RW'(HEIGHT - 1);
    assign w_drop     = src_valid && w_full;
    assign w_wr_data  = {r_col == '0 && r_row == '0, w_last_col, src_data};

    // Position advances on dropped pixels too, so tags stay frame-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (src_valid) begin
                r_col <= w_last_col ? '0 : r_col + CW'(1);
                if (w_last_col) r_row <= w_last_row ? '0 : r_row + RW'(1);
            end
            r_frame_done <= src_valid && w_last_col && w_last_row;
            r_overflow   <= w_drop || (r_overflow && !clr_overflow);
        end
    end

    axis_fwft_fifo #(
        .DW    (PIX_W + TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (src_valid),
        .wr_data (w_wr_data),
        .full    (w_full),
        .rd_en   (m_axis_tready && !w_empty),
        .rd_data (w_rd_data),
        .empty   (w_empty),
        .count   (w_count)
    );

    // Payload is forced to zero while idle so nothing uninitialised leaves the block.
    assign m_axis_tvalid = w_count != '0;
    assign m_axis_tdata  = m_axis_tvalid ? w_rd_data[PIX_W-1:0] : '0;
    assign m_axis_tuser  = m_axis_tvalid && w_rd_data[TAG_SOF];
    assign m_axis_tlast  = m_axis_tvalid && w_rd_data[TAG_EOL];
    assign overflow      = r_overflow;
    assign frame_done    = r_frame_done;

`ifdef CLAHE_AXIS_OUT_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_frame_cnt <= r_frame_done ? r_frame_cnt + 16'd1 : r_frame_cnt;
            r_drop_cnt  <= clr_overflow ? {15'd0, w_drop} :
                           (w_drop && r_drop_cnt != 16'hFFFF) ? r_drop_cnt + 16'd1 : r_drop_cnt;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif
endmodule

// File: tb/tb_clahe_axis_out.sv
// tb_clahe_axis_out: scoreboard bench for clahe_axis_out at FIFO depths 4 and 64 (WIDTH=4, HEIGHT=2).
// Define CLAHE_AXIS_OUT_FRAME_CNT_EN to also check frame_cnt/drop_cnt.
module tb_clahe_axis_out;
    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        src_valid = 1'b0;
    logic [23:0] src_data = '0;
    logic        tready = 1'b0;
    logic        clr = 1'b0;
    logic        sel = 1'b0;

    logic        a_tv, a_tu, a_tl, a_ov, a_fd;
    logic [23:0] a_td;
    logic        b_tv, b_tu, b_tl, b_ov, b_fd;
    logic [23:0] b_td;
`ifdef CLAHE_AXIS_OUT_FRAME_CNT_EN
    logic [15:0] a_fc, a_dc, b_fc, b_dc;
`endif

    always #5 clk = ~clk;

    clahe_axis_out #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
        .m_axis_tvalid(a_tv), .m_axis_tready(tready), .m_axis_tdata(a_td),
        .m_axis_tuser(a_tu), .m_axis_tlast(a_tl), .overflow(a_ov),
        .clr_overflow(clr), .frame_done(a_fd)
`ifdef CLAHE_AXIS_OUT_FRAME_CNT_EN
        , .frame_cnt(a_fc), .drop_cnt(a_dc)
`endif
    );

    clahe_axis_out #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
        .m_axis_tvalid(b_tv), .m_axis_tready(tready), .m_axis_tdata(b_td),
        .m_axis_tuser(b_tu), .m_axis_tlast(b_tl), .overflow(b_ov),
        .clr_overflow(clr), .frame_done(b_fd)
`ifdef CLAHE_AXIS_OUT_FRAME_CNT_EN
        , .frame_cnt(b_fc), .drop_cnt(b_dc)
`endif
    );

    logic        tv, tu, tl, ov, fd;
    logic [23:0] td;
    assign tv = sel ? b_tv : a_tv;
    assign tu = sel ? b_tu : a_tu;
    assign tl = sel ? b_tl : a_tl;
    assign td = sel ? b_td : a_td;
    assign ov = sel ? b_ov : a_ov;
    assign fd = sel ? b_fd : a_fd;

    int          n_pass = 0;
    int          n_total = 0;
    int          beats = 0;
    logic [25:0] sb[$];
    int          m_cnt = 0;
    int          m_col = 0;
    int          m_row = 0;
    logic        p_stall = 1'b0;
    logic [25:0] p_word = '0;

    // Reference occupancy/position model; expected beats are queued as pixels are driven.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; m_col = 0; m_row = 0; p_stall = 1'b0;
            sb.delete();
        end else begin
            automatic int          dep = sel ? 64 : 4;
            automatic logic        rd  = (m_cnt > 0) && tready;
            automatic logic        wr  = src_valid && (m_cnt < dep);
            automatic logic [25:0] got = {tu, tl, td};
            automatic logic [25:0] exp;
            n_total++;
            if (tv !== (m_cnt > 0)) $display("FAIL tvalid: got %b want %b", tv, m_cnt > 0);
            else n_pass++;
            if (p_stall && tv) begin
                n_total++;
                if (got !== p_word) $display("FAIL stall_hold: got %h want %h", got, p_word);
                else n_pass++;
            end
            if (rd) begin
                exp = sb.pop_front();
                n_total++;
                if (got !== exp) $display("FAIL beat: got %h want %h", got, exp);
                else n_pass++;
            end
            if (src_valid) begin
                if (wr) sb.push_back({m_col == 0 && m_row == 0, m_col == W - 1, src_data});
                if (m_col == W - 1) begin
                    m_col = 0;
                    m_row = (m_row == H - 1) ? 0 : m_row + 1;
                end else m_col++;
            end
            m_cnt = m_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
            p_stall = tv && !tready;
            p_word = got;
            if (tv && tready) beats++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        n_total++;
        if ({a_tv, a_tu, a_tl, a_ov, a_fd, a_td} !== '0)
            $display("FAIL reset_a: got %h want 0", {a_tv, a_tu, a_tl, a_ov, a_fd, a_td});
        else n_pass++;
        n_total++;
        if ({b_tv, b_tu, b_tl, b_ov, b_fd, b_td} !== '0)
            $display("FAIL reset_b: got %h want 0", {b_tv, b_tu, b_tl, b_ov, b_fd, b_td});
        else n_pass++;
`ifdef CLAHE_AXIS_OUT_FRAME_CNT_EN
        n_total++;
        if ({a_fc, a_dc} !== '0) $display("FAIL reset_cnt: got %h want 0", {a_fc, a_dc});
        else n_pass++;
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream;
        sel = 1'b0;
        tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            src_valid = 1'b1;
            src_data = 24'(i);
            tick();
            n_total++;
            if (fd !== (i == 8)) $display("FAIL frame_done_%0d: got %b want %b", i, fd, i == 8);
            else n_pass++;
            if (i == 1) begin
                n_total++;
                if ({tv, tu, td} !== {2'b11, 24'h1}) $display("FAIL first_beat: got %h want %h", {tv, tu, td}, {2'b11, 24'h1});
                else n_pass++;
            end
        end
        src_valid = 1'b0;
        tick();
        n_total++;
        if (fd !== 1'b0) $display("FAIL frame_done_pulse: got %b want 0", fd);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_drop;
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_valid = 1'b1;
            src_data = 24'h11 + 24'(i);
            tick();
        end
        n_total++;
        if (ov !== 1'b0) $display("FAIL ovf_before_drop: got %b want 0", ov);
        else n_pass++;
        src_data = 24'h15;
        tick();
        src_valid = 1'b0;
        n_total++;
        if (ov !== 1'b1) $display("FAIL ovf_on_drop: got %b want 1", ov);
        else n_pass++;
`ifdef CLAHE_AXIS_OUT_FRAME_CNT_EN
        n_total++;
        if (a_dc !== 16'd1) $display("FAIL drop_cnt: got %0d want 1", a_dc);
        else n_pass++;
`endif
        tready = 1'b1;
        idle(5);
        for (int i = 0; i < 4; i++) begin
            src_valid = 1'b1;
            src_data = 24'h16 + 24'(i);
            tick();
        end
        src_valid = 1'b0;
        n_total++;
        if ({tv, tu, td} !== {2'b11, 24'h19}) $display("FAIL sof_after_drop: got %h want %h", {tv, tu, td}, {2'b11, 24'h19});
        else n_pass++;
        idle(3);
    endtask

    task automatic test_ovf_clear;
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_valid = 1'b1;
            src_data = 24'h21 + 24'(i);
            tick();
        end
        src_data = 24'h25;
        clr = 1'b1;
        tick();
        src_valid = 1'b0;
        n_total++;
        if (ov !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", ov);
        else n_pass++;
        tick();
        clr = 1'b0;
        n_total++;
        if (ov !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ov);
        else n_pass++;
`ifdef CLAHE_AXIS_OUT_FRAME_CNT_EN
        n_total++;
        if (a_dc !== 16'd0) $display("FAIL drop_cnt_clear: got %0d want 0", a_dc);
        else n_pass++;
`endif
        tready = 1'b1;
        idle(6);
    endtask

    task automatic test_toggle;
        do_reset();
        sel = 1'b1;
        beats = 0;
        for (int i = 0; i < 16; i++) begin
            tready = (i % 2 == 0);
            src_valid = 1'b1;
            src_data = 24'h100 + 24'(i);
            tick();
        end
        src_valid = 1'b0;
        tready = 1'b1;
        idle(12);
        n_total++;
        if (ov !== 1'b0) $display("FAIL toggle_ovf: got %b want 0", ov);
        else n_pass++;
        n_total++;
        if (beats !== 16) $display("FAIL toggle_beats: got %0d want 16", beats);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        sel = 1'b0;
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src_valid = 1'b1;
            src_data = 24'h31 + 24'(i);
            tick();
        end
        src_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        n_total++;
        if ({tv, ov} !== 2'b00) $display("FAIL mid_reset_out: got %b want 00", {tv, ov});
        else n_pass++;
        rst_n = 1'b1;
        tready = 1'b1;
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            src_valid = 1'b1;
            src_data = 24'h41 + 24'(i);
            tick();
            if (i == 0) begin
                n_total++;
                if ({tv, tu, td} !== {2'b11, 24'h41}) $display("FAIL post_reset_sof: got %h want %h", {tv, tu, td}, {2'b11, 24'h41});
                else n_pass++;
            end
        end
        src_valid = 1'b0;
        idle(3);
        n_total++;
        if (beats !== 8) $display("FAIL post_reset_beats: got %0d want 8", beats);
        else n_pass++;
    endtask

    task automatic test_frames;
        int fd_seen;
        do_reset();
        sel = 1'b0;
        tready = 1'b1;
        fd_seen = 0;
        for (int i = 0; i < 3 * W * H; i++) begin
            src_valid = 1'b1;
            src_data = 24'h500 + 24'(i);
            tick();
            if (fd) fd_seen++;
        end
        src_valid = 1'b0;
        tick();
        if (fd) fd_seen++;
        idle(2);
        n_total++;
        if (fd_seen !== 3) $display("FAIL frame_done_count: got %0d want 3", fd_seen);
        else n_pass++;
`ifdef CLAHE_AXIS_OUT_FRAME_CNT_EN
        n_total++;
        if (a_fc !== 16'd3) $display("FAIL frame_cnt: got %0d want 3", a_fc);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_drop();
        test_ovf_clear();
        test_toggle();
        test_reset_mid();
        test_frames();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
